// File: rtl/lsu_ctrl.sv
// Load/store controller between a CPU request port and a word-wide data memory.
// Sub-word stores are performed as read-modify-write; illegal requests are answered with an error.
module lsu_ctrl #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RMW_RD,
        RMW_WR,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    function automatic logic req_is_err(input logic wr, input logic [2:0] f3,
                                        input logic [31:0] a);
        logic illegal;
        logic misaligned;
        illegal    = wr ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 > 3'd5));
        misaligned = ((f3[1:0] == 2'd1) && a[0]) ||
                     ((f3[1:0] == 2'd2) && (a[1:0] != 2'd0));
        return illegal || misaligned || (a >= 32'(MEM_BYTES));
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (f3)
            3'd0:    r = 32'(b);
            3'd1:    r = 32'(h);
            3'd4:    r = {24'd0, b};
            3'd5:    r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        if (f3[1:0] == 2'd0) begin
            r[{off, 3'b000} +: 8] = wd[7:0];
        end else begin
            r[{off[1], 4'b0000} +: 16] = wd[15:0];
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_wdata_d = '0;
        write_d     = write_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d     = req_write;
                    funct3_d    = req_funct3;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (req_is_err(req_write, req_funct3, req_addr)) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (!req_write) begin
                        state_d    = ACCESS;
                        mem_read_d = 1'b1;
                    end else if (req_funct3[1:0] == 2'd2) begin
                        state_d     = ACCESS;
                        mem_write_d = 1'b1;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d    = RMW_RD;
                        mem_read_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Load data is captured here; a word store completes on this edge.
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                if (!write_q) begin
                    rsp_rdata_d = load_extract(mem_rdata, funct3_q, addr_q[1:0]);
                end
            end
            RMW_RD: begin
                state_d     = RMW_WR;
                mem_write_d = 1'b1;
                mem_wdata_d = store_merge(mem_rdata, wdata_q, funct3_q, addr_q[1:0]);
            end
            RMW_WR: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            write_q     <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_wdata_q <= mem_wdata_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array reference model, word-wide memory environment,
// directed cases followed by randomized requests, mid-operation reset and back-to-back traffic.
module tb_lsu_ctrl;

    localparam int MEM = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;
    int both_cnt = 0;
    logic        mem_init;
    logic [31:0] last_rdata;
    logic [7:0]  ref_mem [0:MEM-1];
    logic [31:0] wmem [0:MEM/4-1];

    lsu_ctrl #(.MEM_BYTES(MEM)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_read ? wmem[mem_addr[7:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM/4; i++)
                wmem[i] <= {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
        end else if (mem_write) begin
            wmem[mem_addr[7:2]] <= mem_wdata;
        end
        if (mem_write) wr_pulses <= wr_pulses + 1;
        if (mem_write && mem_read) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the access rules, on a byte-addressed memory.
    function automatic void ref_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, output logic e_err,
                                   output logic [31:0] e_rdata, output int e_lat,
                                   output logic [31:0] e_wdata, output int e_nrd,
                                   output int e_nwr);
        int     n;
        int     base;
        longint v;
        logic   legal;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = w ? (f3 <= 3'd2)
                  : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        e_err   = !legal || ((a % 32'(n)) != 0) || (a >= 32'(MEM));
        e_rdata = '0;
        e_wdata = '0;
        e_nrd   = 0;
        e_nwr   = 0;
        if (e_err) begin
            e_lat = 1;
        end else if (!w) begin
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(ref_mem[int'(a) + i]) << (8 * i);
            if (f3 == 3'd0 && v >= 128) v -= 256;
            if (f3 == 3'd1 && v >= 32768) v -= 65536;
            e_rdata = v[31:0];
            e_lat   = 2;
            e_nrd   = 1;
        end else begin
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            base    = int'(a) & ~3;
            e_wdata = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
            e_lat   = (n == 4) ? 2 : 3;
            e_nrd   = (n == 4) ? 0 : 1;
            e_nwr   = 1;
        end
    endfunction

    // Issue one request from an IDLE negedge and follow it to its response.
    task automatic run_req(input string tag, input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        logic        e_err, g_err, got, addr_ok, quiet_ok;
        logic [31:0] e_rdata, e_wdata, g_rdata, g_wdata;
        int          e_lat, e_nrd, e_nwr, cyc, lat, nrd, nwr;
        ref_op(w, f3, a, wd, e_err, e_rdata, e_lat, e_wdata, e_nrd, e_nwr);
        chk($sformatf("%s.ready_idle", tag), req_ready, 1'b1);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        got = 0; cyc = 0; lat = 0; nrd = 0; nwr = 0;
        addr_ok = 1; quiet_ok = 1; g_rdata = '0; g_wdata = '0; g_err = 0;
        while (!got && cyc < 6) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0;
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                g_wdata = mem_wdata;
            end
            if ((mem_read || mem_write) && mem_addr !== {a[31:2], 2'b00}) addr_ok = 0;
            if (req_ready) quiet_ok = 0;
            if (rsp_valid) begin
                got = 1; lat = cyc; g_rdata = rsp_rdata; g_err = rsp_err;
                if (mem_read || mem_write) quiet_ok = 0;
            end else if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
                quiet_ok = 0;
            end
        end
        last_rdata = g_rdata;
        chk($sformatf("%s.latency", tag), 32'(lat), 32'(e_lat));
        chk($sformatf("%s.err", tag), g_err, e_err);
        chk($sformatf("%s.rdata", tag), g_rdata, e_rdata);
        chk($sformatf("%s.n_read", tag), 32'(nrd), 32'(e_nrd));
        chk($sformatf("%s.n_write", tag), 32'(nwr), 32'(e_nwr));
        chk($sformatf("%s.wdata", tag), g_wdata, e_wdata);
        chk($sformatf("%s.addr", tag), addr_ok, 1'b1);
        chk($sformatf("%s.quiet", tag), quiet_ok, 1'b1);
        @(negedge clk);
        chk($sformatf("%s.rsp_one_cycle", tag), rsp_valid, 1'b0);
        chk($sformatf("%s.ready_after", tag), req_ready, 1'b1);
    endtask

    initial begin
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a, wd, tgt_word, e_rdata, e_wdata;
        logic        e_err;
        int          e_lat, e_nrd, e_nwr, pick, pulses0, bad;

        rst_n = 1'b0; mem_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < MEM; i++) ref_mem[i] = 8'($urandom);
        ref_mem[16] = 8'hBB; ref_mem[17] = 8'hAA; ref_mem[18] = 8'h99; ref_mem[19] = 8'h88;
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        chk("rst.rsp_valid", rsp_valid, 1'b0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.rsp_err", rsp_err, 1'b0);
        chk("rst.mem_read", mem_read, 1'b0);
        chk("rst.mem_write", mem_write, 1'b0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        run_req("lh_12", 1'b0, 3'd1, 32'h12, 32'd0);
        chk("lh_12.const", last_rdata, 32'hFFFF_8899);
        run_req("lbu_11", 1'b0, 3'd4, 32'h11, 32'd0);
        chk("lbu_11.const", last_rdata, 32'h0000_00AA);
        run_req("lb_11", 1'b0, 3'd0, 32'h11, 32'd0);
        chk("lb_11.const", last_rdata, 32'hFFFF_FFAA);
        run_req("lw_10", 1'b0, 3'd2, 32'h10, 32'd0);
        chk("lw_10.const", last_rdata, 32'h8899_AABB);
        run_req("sh_10", 1'b1, 3'd1, 32'h10, 32'h1234_5678);
        run_req("lw_10b", 1'b0, 3'd2, 32'h10, 32'd0);
        chk("lw_10b.const", last_rdata, 32'h8899_5678);
        run_req("lhu_02", 1'b0, 3'd5, 32'h02, 32'd0);
        run_req("sb_33", 1'b1, 3'd0, 32'h33, 32'hCAFE_F00D);
        run_req("lw_30", 1'b0, 3'd2, 32'h30, 32'd0);

        run_req("err_lw_13", 1'b0, 3'd2, 32'h13, 32'd0);
        run_req("err_sh_05", 1'b1, 3'd1, 32'h05, 32'hFFFF);
        run_req("err_lb_100", 1'b0, 3'd0, 32'h100, 32'd0);
        run_req("err_ld_f3", 1'b0, 3'd3, 32'h20, 32'd0);
        run_req("err_st_f3", 1'b1, 3'd4, 32'h20, 32'h55);
        run_req("edge_lb_ff", 1'b0, 3'd0, 32'hFF, 32'd0);

        for (int k = 0; k < 60; k++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin
                f3 = 3'($urandom_range(0, 7));
            end else if (w) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                pick = int'($urandom_range(0, 4));
                f3 = (pick >= 3) ? 3'(pick + 1) : 3'(pick);
            end
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(256, 1023));
            else if ($urandom_range(0, 3) != 0)
                a = (f3[1:0] == 2'd1) ? {a[31:1], 1'b0} :
                    (f3[1:0] == 2'd2) ? {a[31:2], 2'b00} : a;
            wd = $urandom;
            run_req($sformatf("rnd%0d", k), w, f3, a, wd);
        end

        // Reset while an SB sits in its read phase: the merged word must never land.
        tgt_word = wmem[9];
        pulses0 = wr_pulses;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'h25; req_wdata = 32'h0000_0042;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort.in_rmw_rd", mem_read, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.mem_read", mem_read, 1'b0);
        chk("abort.mem_write", mem_write, 1'b0);
        chk("abort.rsp_valid", rsp_valid, 1'b0);
        chk("abort.mem_addr", mem_addr, 32'd0);
        chk("abort.mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("abort.no_write", 32'(wr_pulses - pulses0), 32'd0);
        chk("abort.word_kept", wmem[9], tgt_word);
        run_req("after_rst_lw", 1'b0, 3'd2, 32'h24, 32'd0);
        chk("after_rst_lw.word", last_rdata, tgt_word);

        // Back-to-back traffic with req_valid held high throughout.
        req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w  = (k % 2 == 0);
            a  = 32'h40 + 32'(4 * (k / 2));
            wd = $urandom;
            req_write = w; req_funct3 = 3'd2; req_addr = a; req_wdata = wd;
            ref_op(w, 3'd2, a, wd, e_err, e_rdata, e_lat, e_wdata, e_nrd, e_nwr);
            chk($sformatf("b2b%0d.ready", k), req_ready, 1'b1);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("b2b%0d.busy1", k), req_ready, 1'b0);
            chk($sformatf("b2b%0d.wr", k), mem_write, w);
            if (w) chk($sformatf("b2b%0d.wdata", k), mem_wdata, e_wdata);
            @(negedge clk);
            chk($sformatf("b2b%0d.busy2", k), req_ready, 1'b0);
            chk($sformatf("b2b%0d.rsp", k), rsp_valid, 1'b1);
            chk($sformatf("b2b%0d.rdata", k), rsp_rdata, e_rdata);
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);

        bad = 0;
        for (int i = 0; i < MEM/4; i++)
            if (wmem[i] !== {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]})
                bad++;
        chk("final.mem_words_differing", 32'(bad), 32'd0);
        chk("final.read_write_overlap", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
